// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_pkg
//  Brief    : Shared types and encodings for the SoC reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_PERIPH_GAP = 3'd2,
        ST_CPU_GAP    = 3'd3,
        ST_RUN        = 3'd4,
        ST_SOFT_HOLD  = 3'd5
    } seq_state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_timer
//  Brief    : Saturating up-counter with clear, enable and terminal compare.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_seq_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Compares the pre-edge count so the owner acts on the Nth edge of a stay.
    assign at_term = (r_count == terminal);

endmodule : reset_seq_timer
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Brief    : Ordered release of memory, peripheral and core reset domains,
//             with warm (soft) reset of core+peripherals and a reset cause.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 8,
    parameter int INIT_TIMEOUT = 1024,
    parameter int SOFT_PULSE   = 32
) (
    input  logic       clk,
    input  logic       fabric_reset_n,
    input  logic       mem_init_done,
    input  logic       soft_rst_req,
    output logic       mem_reset_n,
    output logic       periph_reset_n,
    output logic       cpu_reset_n,
    output logic       seq_done,
    output logic       init_timeout_err,
    output logic [1:0] rst_cause
);

    localparam int MAX_PARAM = max_of(max_of(HOLD_CYCLES, STAGE_GAP),
                                      max_of(INIT_TIMEOUT, SOFT_PULSE));
    localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

    localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] INIT_TERM  = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PULSE_TERM = CNT_W'(SOFT_PULSE - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic             w_mem_n;
    logic             w_periph_n;
    logic             w_cpu_n;
    logic             w_done;
    logic             w_err;
    logic [1:0]       w_cause;
    logic             w_timer_clear;
    logic             w_timer_en;
    logic [CNT_W-1:0] w_timer_term;
    logic             w_at_term;

    reset_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (fabric_reset_n),
        .clear    (w_timer_clear),
        .enable   (w_timer_en),
        .terminal (w_timer_term),
        .at_term  (w_at_term)
    );

    always_ff @(posedge clk or negedge fabric_reset_n) begin
        if (!fabric_reset_n) begin
            r_state          <= ST_HOLD;
            mem_reset_n      <= 1'b0;
            periph_reset_n   <= 1'b0;
            cpu_reset_n      <= 1'b0;
            seq_done         <= 1'b0;
            init_timeout_err <= 1'b0;
            rst_cause        <= CAUSE_POR;
        end else begin
            r_state          <= w_state_next;
            mem_reset_n      <= w_mem_n;
            periph_reset_n   <= w_periph_n;
            cpu_reset_n      <= w_cpu_n;
            seq_done         <= w_done;
            init_timeout_err <= w_err;
            rst_cause        <= w_cause;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_n      = mem_reset_n;
        w_periph_n   = periph_reset_n;
        w_cpu_n      = cpu_reset_n;
        w_done       = seq_done;
        w_err        = init_timeout_err;
        w_cause      = rst_cause;
        w_timer_en   = 1'b0;
        w_timer_term = HOLD_TERM;

        case (r_state)
            ST_HOLD: begin
                w_timer_en   = 1'b1;
                w_timer_term = HOLD_TERM;
                if (w_at_term) begin
                    w_mem_n      = 1'b1;
                    w_state_next = ST_WAIT_INIT;
                end
            end
            ST_WAIT_INIT: begin
                w_timer_en   = 1'b1;
                w_timer_term = INIT_TERM;
                if (mem_init_done) begin
                    w_state_next = ST_PERIPH_GAP;
                end else if (w_at_term) begin
                    w_err        = 1'b1;
                    w_state_next = ST_PERIPH_GAP;
                end
            end
            ST_PERIPH_GAP: begin
                w_timer_en   = 1'b1;
                w_timer_term = GAP_TERM;
                if (w_at_term) begin
                    w_periph_n   = 1'b1;
                    w_state_next = ST_CPU_GAP;
                end
            end
            ST_CPU_GAP: begin
                w_timer_en   = 1'b1;
                w_timer_term = GAP_TERM;
                if (w_at_term) begin
                    w_cpu_n      = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Memory stays out of reset: a warm reset never disturbs loaded contents.
                if (soft_rst_req) begin
                    w_cpu_n      = 1'b0;
                    w_periph_n   = 1'b0;
                    w_done       = 1'b0;
                    w_cause      = CAUSE_SOFT;
                    w_state_next = ST_SOFT_HOLD;
                end
            end
            ST_SOFT_HOLD: begin
                w_timer_en   = 1'b1;
                w_timer_term = PULSE_TERM;
                if (w_at_term) begin
                    w_state_next = ST_PERIPH_GAP;
                end
            end
            default: begin
                w_state_next = ST_HOLD;
            end
        endcase

        w_timer_clear = (w_state_next != r_state);
    end

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Brief    : Directed bench for reset_sequencer with an edge-tagged scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int SIG_MEM    = 0;
    localparam int SIG_PERIPH = 1;
    localparam int SIG_CPU    = 2;
    localparam int SIG_DONE   = 3;
    localparam int SIG_ERR    = 4;
    localparam int SIG_CAUSE  = 5;
    localparam int WAIT_LIMIT = 3000;

    typedef struct {
        int         edge_no;
        int         sig;
        logic [1:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_init_done = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       mem_reset_n;
    logic       periph_reset_n;
    logic       cpu_reset_n;
    logic       seq_done;
    logic       init_timeout_err;
    logic [1:0] rst_cause;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_miss;

    reset_sequencer dut (
        .clk              (clk),
        .fabric_reset_n   (rst_n),
        .mem_init_done    (mem_init_done),
        .soft_rst_req     (soft_rst_req),
        .mem_reset_n      (mem_reset_n),
        .periph_reset_n   (periph_reset_n),
        .cpu_reset_n      (cpu_reset_n),
        .seq_done         (seq_done),
        .init_timeout_err (init_timeout_err),
        .rst_cause        (rst_cause)
    );

    initial forever #5 clk = ~clk;

    // Edge number: count of rising edges seen with reset released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [1:0] pick(input int s);
        case (s)
            SIG_MEM:    return {1'b0, mem_reset_n};
            SIG_PERIPH: return {1'b0, periph_reset_n};
            SIG_CPU:    return {1'b0, cpu_reset_n};
            SIG_DONE:   return {1'b0, seq_done};
            SIG_ERR:    return {1'b0, init_timeout_err};
            default:    return rst_cause;
        endcase
    endfunction

    task automatic expect_at(input int e, input int s, input logic [1:0] v, input string nm);
        exp_t x;
        x.edge_no = e;
        x.sig     = s;
        x.val     = v;
        x.name    = nm;
        q.push_back(x);
    endtask

    task automatic expect_reset_values();
        expect_at(0, SIG_MEM,    2'd0, "rst_mem");
        expect_at(0, SIG_PERIPH, 2'd0, "rst_periph");
        expect_at(0, SIG_CPU,    2'd0, "rst_cpu");
        expect_at(0, SIG_DONE,   2'd0, "rst_done");
        expect_at(0, SIG_ERR,    2'd0, "rst_err");
        expect_at(0, SIG_CAUSE,  2'd0, "rst_cause");
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < WAIT_LIMIT) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_edge: reached edge %0d, wanted edge %0d", cyc, n);
        end
    endtask

    // Monitor: outputs are examined shortly after each falling clock edge and
    // after any reset assertion; due expectations are popped and compared.
    initial begin
        exp_t e;
        logic [1:0] got;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (q.size() > 0 && q[0].edge_no <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.edge_no < cyc) begin
                    n_miss++;
                    $display("FAIL %s: check for edge %0d missed, now at edge %0d",
                             e.name, e.edge_no, cyc);
                end else begin
                    got = pick(e.sig);
                    if (got !== e.val) begin
                        n_miss++;
                        $display("FAIL %s @edge %0d: got %0d expected %0d",
                                 e.name, e.edge_no, got, e.val);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        n_vec  = 0;
        n_miss = 0;

        // Reset held from time zero.
        #12;
        expect_reset_values();
        @(negedge clk);
        @(negedge clk);

        // POR with memory init already done, then soft resets.
        expect_at(15, SIG_MEM,    2'd0, "por_mem_pre");
        expect_at(16, SIG_MEM,    2'd1, "por_mem_rise");
        expect_at(24, SIG_PERIPH, 2'd0, "por_periph_pre");
        expect_at(25, SIG_PERIPH, 2'd1, "por_periph_rise");
        expect_at(32, SIG_CPU,    2'd0, "por_cpu_pre");
        expect_at(32, SIG_DONE,   2'd0, "por_done_pre");
        expect_at(33, SIG_CPU,    2'd1, "por_cpu_rise");
        expect_at(33, SIG_DONE,   2'd1, "por_done_rise");
        expect_at(33, SIG_ERR,    2'd0, "por_err");
        expect_at(39, SIG_CAUSE,  2'd0, "por_cause");
        expect_at(40, SIG_CPU,    2'd0, "soft_cpu_low");
        expect_at(40, SIG_PERIPH, 2'd0, "soft_periph_low");
        expect_at(40, SIG_DONE,   2'd0, "soft_done_low");
        expect_at(40, SIG_CAUSE,  2'd1, "soft_cause");
        expect_at(40, SIG_MEM,    2'd1, "soft_mem_kept");
        expect_at(79, SIG_PERIPH, 2'd0, "soft_periph_pre");
        expect_at(80, SIG_PERIPH, 2'd1, "soft_periph_rise");
        expect_at(87, SIG_CPU,    2'd0, "soft_cpu_pre");
        expect_at(88, SIG_CPU,    2'd1, "cpugap_req_ignored");
        expect_at(88, SIG_DONE,   2'd1, "soft_done_rise");
        expect_at(100, SIG_CPU,   2'd0, "soft2_cpu_low");
        expect_at(134, SIG_PERIPH, 2'd0, "soft2_periph_gap");
        expect_at(134, SIG_MEM,    2'd1, "soft2_mem_kept");
        expect_at(134, SIG_CAUSE,  2'd1, "soft2_cause");
        rst_n = 1'b1;

        wait_cyc(39);
        soft_rst_req = 1'b1;
        wait_cyc(40);
        soft_rst_req = 1'b0;
        // Request during CPU_GAP (edges 81..88) must not disturb release.
        wait_cyc(82);
        soft_rst_req = 1'b1;
        wait_cyc(85);
        soft_rst_req = 1'b0;
        wait_cyc(99);
        soft_rst_req = 1'b1;
        wait_cyc(100);
        soft_rst_req = 1'b0;

        // Asynchronous abort mid PERIPH_GAP.
        wait_cyc(135);
        #2;
        expect_reset_values();
        mem_init_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Restart with memory init arriving late.
        expect_at(15,  SIG_MEM,    2'd0, "late_mem_pre");
        expect_at(16,  SIG_MEM,    2'd1, "late_mem_rise");
        expect_at(60,  SIG_PERIPH, 2'd0, "late_periph_wait");
        expect_at(107, SIG_PERIPH, 2'd0, "late_periph_pre");
        expect_at(108, SIG_PERIPH, 2'd1, "late_periph_rise");
        expect_at(115, SIG_CPU,    2'd0, "late_cpu_pre");
        expect_at(116, SIG_CPU,    2'd1, "late_cpu_rise");
        expect_at(116, SIG_DONE,   2'd1, "late_done_rise");
        expect_at(116, SIG_ERR,    2'd0, "late_err");
        expect_at(116, SIG_CAUSE,  2'd0, "late_cause");
        rst_n = 1'b1;
        wait_cyc(99);
        mem_init_done = 1'b1;

        // Memory init never arrives: timeout path.
        wait_cyc(120);
        mem_init_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        expect_at(1039, SIG_ERR,    2'd0, "to_err_pre");
        expect_at(1040, SIG_ERR,    2'd1, "to_err_set");
        expect_at(1047, SIG_PERIPH, 2'd0, "to_periph_pre");
        expect_at(1048, SIG_PERIPH, 2'd1, "to_periph_rise");
        expect_at(1055, SIG_CPU,    2'd0, "to_cpu_pre");
        expect_at(1056, SIG_CPU,    2'd1, "to_cpu_rise");
        expect_at(1056, SIG_DONE,   2'd1, "to_done_rise");
        expect_at(1100, SIG_ERR,    2'd1, "to_err_sticky");
        expect_at(1100, SIG_DONE,   2'd1, "to_done_hold");
        rst_n = 1'b1;
        wait_cyc(1060);
        mem_init_done = 1'b1;
        wait_cyc(1101);
        #2;
        expect_at(0, SIG_ERR,   2'd0, "to_err_cleared");
        expect_at(0, SIG_MEM,   2'd0, "to_mem_reset");
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_vec  += q.size();
            n_miss += q.size();
            $display("FAIL drain: %0d checks left pending, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
